// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
//
// Purpose:
//   CPU-side transmit framer. The CPU writes 16-bit words over the io bus
//   into an internal word FIFO and then issues a send command. The block
//   turns the buffered words into a checksummed byte frame and hands it,
//   one byte at a time, to a shared uart through its
//   transmit / tx_byte / is_transmitting handshake.
//
//   Frame layout: HDR_BYTE, LEN, {hi, lo} for each of LEN words, CHK
//   where CHK is the XOR of every preceding byte of the frame.
//
// Register map (io bus, 16-bit addresses):
//   0x0000 W  DATA    push a word into the FIFO (dropped and overflow set
//                     when the FIFO is full)
//   0x0002 W  CTRL    bit0 send, bit1 clear overflow
//   0x0002 R  STATUS  [8:4] count, [3] overflow, [2] full, [1] empty, [0] busy
//   0x0004 R  LASTLEN {8'b0, length of the most recently started frame}
//
// Ports:
//   clk_i              system clock, rising edge
//   rst_n_i            asynchronous active-low reset
//   io_stb_i           io bus strobe
//   io_we_i            io bus write enable (1 = write, 0 = read)
//   io_addr_i[15:0]    io bus register address
//   io_dat_i[15:0]     io bus write data
//   io_ack_o           io bus acknowledge (zero wait states)
//   io_dat_o[15:0]     io bus read data (combinational)
//   tx_byte_o[7:0]     byte presented to the uart
//   transmit_o         one-cycle start pulse to the uart
//   is_transmitting_i  uart busy flag
//   busy_o             frame in progress
// ---------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  HDR_BYTE = 8'h20,
    parameter int          CW       = $clog2(DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        io_stb_i,
    input  logic        io_we_i,
    input  logic [15:0] io_addr_i,
    input  logic [15:0] io_dat_i,
    output logic        io_ack_o,
    output logic [15:0] io_dat_o,
    output logic [7:0]  tx_byte_o,
    output logic        transmit_o,
    input  logic        is_transmitting_i,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [15:0] ADDR_DATA    = 16'h0000;
    localparam logic [15:0] ADDR_CTRL    = 16'h0002;
    localparam logic [15:0] ADDR_LASTLEN = 16'h0004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PULSE,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_e;

    typedef enum logic [2:0] {
        PH_HDR,
        PH_LEN,
        PH_HI,
        PH_LO,
        PH_CHK
    } phase_e;

    // FSM and frame registers
    state_e         state_q, state_d;
    phase_e         phase_q, phase_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic [7:0]     chk_q, chk_d;
    logic [CW-1:0]  words_rem_q, words_rem_d;
    logic [7:0]     last_len_q, last_len_d;

    // FIFO registers
    logic [15:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;

    // Bus decode and FIFO control
    logic           wr_stb;
    logic           data_wr;
    logic           ctrl_wr;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           ovf_set;
    logic           ovf_clr;
    logic           send_ok;
    logic [15:0]    head_word;
    logic [15:0]    status_word;

    // -----------------------------------------------------------------------
    // io bus decode. Full/empty come from the registered count, so they
    // reflect the FIFO as it stands before the current edge.
    // -----------------------------------------------------------------------
    assign io_ack_o   = io_stb_i;
    assign wr_stb     = io_stb_i & io_we_i;
    assign data_wr    = wr_stb && (io_addr_i == ADDR_DATA);
    assign ctrl_wr    = wr_stb && (io_addr_i == ADDR_CTRL);

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    assign push       = data_wr & ~fifo_full;
    assign ovf_set    = data_wr & fifo_full;
    assign ovf_clr    = ctrl_wr & io_dat_i[1];
    assign send_ok    = ctrl_wr & io_dat_i[0] & (state_q == ST_IDLE) & ~fifo_empty;

    // A word leaves the FIFO once its low byte has been launched.
    assign pop        = (state_q == ST_PULSE) && (phase_q == PH_LO);

    assign head_word  = mem_q[rd_ptr_q];

    assign busy_o     = (state_q != ST_IDLE);
    assign transmit_o = (state_q == ST_PULSE);
    assign tx_byte_o  = tx_byte_q;

    // -----------------------------------------------------------------------
    // Read mux, combinational while a read strobe is present.
    // -----------------------------------------------------------------------
    assign status_word = {7'b0, 5'(count_q), ovf_q, fifo_full, fifo_empty, busy_o};

    always_comb begin
        io_dat_o = 16'h0000;
        if (io_stb_i && !io_we_i) begin
            case (io_addr_i)
                ADDR_CTRL:    io_dat_o = status_word;
                ADDR_LASTLEN: io_dat_o = {8'h00, last_len_q};
                default:      io_dat_o = 16'h0000;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FIFO next-state. A simultaneous push and pop both take effect and
    // leave the count unchanged; pointers wrap naturally since DEPTH is a
    // power of two. A clear-overflow request beats a same-edge overflow.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO storage needs no reset; only the pointers and count define content.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= io_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Framing FSM next-state. words_rem counts words still to be popped for
    // this frame; it is decremented at the LO pulse, so by WAIT_LO it tells
    // whether another HI/LO pair follows or the checksum is due. LEN comes
    // from last_len, which is latched at send time.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        tx_byte_d   = tx_byte_q;
        chk_d       = chk_q;
        words_rem_d = words_rem_q;
        last_len_d  = last_len_q;

        case (state_q)
            ST_IDLE: begin
                if (send_ok) begin
                    state_d     = ST_LOAD;
                    phase_d     = PH_HDR;
                    chk_d       = 8'h00;
                    words_rem_d = count_q;
                    last_len_d  = 8'(count_q);
                end
            end

            ST_LOAD: begin
                case (phase_q)
                    PH_HDR:  tx_byte_d = HDR_BYTE;
                    PH_LEN:  tx_byte_d = last_len_q;
                    PH_HI:   tx_byte_d = head_word[15:8];
                    PH_LO:   tx_byte_d = head_word[7:0];
                    PH_CHK:  tx_byte_d = chk_q;
                    default: tx_byte_d = tx_byte_q;
                endcase
                state_d = ST_PULSE;
            end

            ST_PULSE: begin
                chk_d = chk_q ^ tx_byte_q;
                if (pop) begin
                    words_rem_d = words_rem_q - CW'(1);
                end
                state_d = ST_WAIT_HI;
            end

            ST_WAIT_HI: begin
                if (is_transmitting_i) begin
                    state_d = ST_WAIT_LO;
                end
            end

            ST_WAIT_LO: begin
                if (!is_transmitting_i) begin
                    state_d = ST_LOAD;
                    case (phase_q)
                        PH_HDR: phase_d = PH_LEN;
                        PH_LEN: phase_d = PH_HI;
                        PH_HI:  phase_d = PH_LO;
                        PH_LO:  phase_d = (words_rem_q == '0) ? PH_CHK : PH_HI;
                        PH_CHK: begin
                            phase_d = PH_HDR;
                            state_d = ST_IDLE;
                        end
                        default: begin
                            phase_d = PH_HDR;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = PH_HDR;
            end
        endcase
    end

    // Framing state register; reset aborts any frame in flight immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_HDR;
            tx_byte_q   <= 8'h00;
            chk_q       <= 8'h00;
            words_rem_q <= '0;
            last_len_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tx_byte_q   <= tx_byte_d;
            chk_q       <= chk_d;
            words_rem_q <= words_rem_d;
            last_len_q  <= last_len_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_tx
//
// Self-checking bench for uart_frame_tx. A small uart model answers each
// transmit pulse with an is_transmitting window. Expected frame bytes are
// built from a word-queue model when a send is issued and compared by a
// monitor as the DUT launches each byte. Register accesses come from a
// vector table plus hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;

    localparam int         DEPTH    = 16;
    localparam logic [7:0] HDR_BYTE = 8'h20;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        io_stb_i = 1'b0;
    logic        io_we_i = 1'b0;
    logic [15:0] io_addr_i = 16'h0000;
    logic [15:0] io_dat_i = 16'h0000;
    logic        io_ack_o;
    logic [15:0] io_dat_o;
    logic [7:0]  tx_byte_o;
    logic        transmit_o;
    logic        is_transmitting_i = 1'b0;
    logic        busy_o;

    int          checks = 0;
    int          failures = 0;
    int          pulseCount = 0;
    int          base = 0;
    bit          uartHold = 1'b0;
    logic        prevTx = 1'b0;
    logic [7:0]  monExp;
    logic [7:0]  expQ [$];
    logic [15:0] modelQ [$];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] dat;
        logic [15:0] expRd;
    } vec_t;

    vec_t vecs [6];

    uart_frame_tx #(
        .DEPTH    (DEPTH),
        .HDR_BYTE (HDR_BYTE)
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .io_stb_i          (io_stb_i),
        .io_we_i           (io_we_i),
        .io_addr_i         (io_addr_i),
        .io_dat_i          (io_dat_i),
        .io_ack_o          (io_ack_o),
        .io_dat_o          (io_dat_o),
        .tx_byte_o         (tx_byte_o),
        .transmit_o        (transmit_o),
        .is_transmitting_i (is_transmitting_i),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [15:0] dat);
        @(negedge clk_i);
        io_stb_i  = 1'b1;
        io_we_i   = 1'b1;
        io_addr_i = addr;
        io_dat_i  = dat;
        @(negedge clk_i);
        io_stb_i  = 1'b0;
        io_we_i   = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [15:0] addr, input logic [15:0] expRd);
        @(negedge clk_i);
        io_stb_i  = 1'b1;
        io_we_i   = 1'b0;
        io_addr_i = addr;
        #1;
        checkOutput({name, "_ack"}, io_ack_o, 1);
        checkOutput(name, io_dat_o, expRd);
        io_stb_i  = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.we) begin
            busWrite(v.addr, v.dat);
        end else begin
            readCheck($sformatf("vec%0d_rd", idx), v.addr, v.expRd);
        end
    endtask

    // Model FIFO keeps at most DEPTH words; extra pushes are dropped.
    task automatic pushWord(input logic [15:0] w);
        busWrite(16'h0000, w);
        if (modelQ.size() < DEPTH) begin
            modelQ.push_back(w);
        end
    endtask

    // Issue a send and queue the frame the model says must follow.
    task automatic sendFrame();
        logic [7:0]  chk;
        logic [15:0] w;
        int          len;
        busWrite(16'h0002, 16'h0001);
        len = modelQ.size();
        chk = 8'h00;
        expQ.push_back(HDR_BYTE);
        chk ^= HDR_BYTE;
        expQ.push_back(8'(len));
        chk ^= 8'(len);
        for (int i = 0; i < len; i++) begin
            w = modelQ.pop_front();
            expQ.push_back(w[15:8]);
            chk ^= w[15:8];
            expQ.push_back(w[7:0]);
            chk ^= w[7:0];
        end
        expQ.push_back(chk);
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 3000 && busy_o; i++) begin
            @(negedge clk_i);
        end
        checkOutput({name, "_done"}, busy_o, 0);
        checkOutput({name, "_all_bytes"}, expQ.size(), 0);
    endtask

    task automatic waitPulses(input int n, input string name);
        for (int i = 0; i < 2000 && pulseCount < n; i++) begin
            @(negedge clk_i);
        end
        checkOutput(name, (pulseCount >= n), 1);
    endtask

    // Monitor: every launched byte must be single-cycle and match the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            if (transmit_o) begin
                pulseCount++;
                checkOutput("pulse_width", prevTx, 0);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_byte actual=%0h required=none", tx_byte_o);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("tx_byte", tx_byte_o, monExp);
                end
            end
            prevTx = transmit_o;
        end
    end

    // Uart model: busy window shortly after each start pulse, unless held off.
    initial begin
        forever begin
            @(negedge clk_i);
            if (transmit_o && !uartHold) begin
                repeat (2) @(negedge clk_i);
                is_transmitting_i = 1'b1;
                repeat (3) @(negedge clk_i);
                is_transmitting_i = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{we: 1'b0, addr: 16'h0002, dat: 16'h0000, expRd: 16'h0002};
        vecs[1] = '{we: 1'b0, addr: 16'h0004, dat: 16'h0000, expRd: 16'h0000};
        vecs[2] = '{we: 1'b0, addr: 16'h0006, dat: 16'h0000, expRd: 16'h0000};
        vecs[3] = '{we: 1'b1, addr: 16'h0006, dat: 16'hFFFF, expRd: 16'h0000};
        vecs[4] = '{we: 1'b1, addr: 16'h0002, dat: 16'h0002, expRd: 16'h0000};
        vecs[5] = '{we: 1'b0, addr: 16'h0002, dat: 16'h0000, expRd: 16'h0002};

        // Reset state
        repeat (3) @(negedge clk_i);
        checkOutput("rst_transmit", transmit_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_tx_byte", tx_byte_o, 0);
        rst_n_i = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end
        checkOutput("table_no_pulse", pulseCount, 0);

        // Two-word frame
        $display("[TB] two-word frame");
        pushWord(16'hA1B2);
        pushWord(16'h0304);
        readCheck("two_word_status", 16'h0002, 16'h0020);
        base = pulseCount;
        sendFrame();
        waitIdle("frame1");
        checkOutput("frame1_pulses", pulseCount - base, 7);
        readCheck("frame1_lastlen", 16'h0004, 16'h0002);
        readCheck("frame1_status", 16'h0002, 16'h0002);

        // Overflow, clear, and a full-depth frame
        $display("[TB] overflow and full-depth frame");
        for (int i = 0; i < 17; i++) begin
            pushWord(16'h1000 + 16'(i * 16'h0111));
        end
        readCheck("ovf_status", 16'h0002, 16'h010C);
        busWrite(16'h0002, 16'h0002);
        readCheck("ovf_cleared", 16'h0002, 16'h0104);
        base = pulseCount;
        sendFrame();
        waitIdle("frame16");
        checkOutput("frame16_pulses", pulseCount - base, 35);
        readCheck("frame16_lastlen", 16'h0004, 16'h0010);
        readCheck("frame16_status", 16'h0002, 16'h0002);

        // Send with empty FIFO is ignored
        $display("[TB] ignored sends");
        base = pulseCount;
        busWrite(16'h0002, 16'h0001);
        repeat (10) @(negedge clk_i);
        checkOutput("empty_send_pulses", pulseCount - base, 0);
        checkOutput("empty_send_busy", busy_o, 0);
        readCheck("empty_send_lastlen", 16'h0004, 16'h0010);

        // Pushes and a second send during a one-word frame
        pushWord(16'h5A5A);
        base = pulseCount;
        sendFrame();
        checkOutput("busy_after_send", busy_o, 1);
        pushWord(16'h1111);
        pushWord(16'h2222);
        busWrite(16'h0002, 16'h0001);
        waitIdle("frame_len1");
        checkOutput("len1_pulses", pulseCount - base, 5);
        readCheck("len1_lastlen", 16'h0004, 16'h0001);
        readCheck("len1_status", 16'h0002, 16'h0020);
        base = pulseCount;
        sendFrame();
        waitIdle("frame_len2");
        checkOutput("len2_pulses", pulseCount - base, 7);
        readCheck("len2_lastlen", 16'h0004, 16'h0002);

        // Reset while waiting for the uart on the third byte
        $display("[TB] reset mid-frame");
        pushWord(16'hCAFE);
        pushWord(16'hBEEF);
        base = pulseCount;
        sendFrame();
        waitPulses(base + 2, "abort_pulse2");
        uartHold = 1'b1;
        waitPulses(base + 3, "abort_pulse3");
        repeat (2) @(negedge clk_i);
        checkOutput("abort_busy_before", busy_o, 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        checkOutput("abort_transmit", transmit_o, 0);
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_tx_byte", tx_byte_o, 0);
        expQ.delete();
        modelQ.delete();
        readCheck("abort_status_in_reset", 16'h0002, 16'h0002);
        uartHold = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        readCheck("abort_status", 16'h0002, 16'h0002);
        readCheck("abort_lastlen", 16'h0004, 16'h0000);
        repeat (5) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
